// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage: ALU op codes, MIPS opcode/funct
// values and the decoded issue-buffer entry.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOR = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } aluop_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        aluop_e      aluop;
        logic        illegal;
    } issue_entry_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: turns an instruction word plus register values into the
// operands and op code the ALU needs. Unsupported encodings yield an all-zero illegal entry.
import alu_pkg::*;

module alu_decode (
    input  logic [31:0]  instr,
    input  logic [31:0]  rs_val,
    input  logic [31:0]  rt_val,
    output issue_entry_t entry
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign shamt         = instr[10:6];
    assign imm           = instr[15:0];
    assign unused_fields = ^instr[25:16];

    always_comb begin
        entry = '0;
        case (opcode)
            OPC_RTYPE: begin
                entry.in1 = rs_val;
                entry.in2 = rt_val;
                case (funct)
                    FN_ADD, FN_ADDU: entry.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: entry.aluop = ALU_SUB;
                    FN_AND:          entry.aluop = ALU_AND;
                    FN_OR:           entry.aluop = ALU_OR;
                    FN_NOR:          entry.aluop = ALU_NOR;
                    FN_SLT:          entry.aluop = ALU_SLT;
                    FN_SLL, FN_SRL: begin
                        // shifts operate on rt; the shift amount rides in operand 2
                        entry.in1   = rt_val;
                        entry.in2   = {27'b0, shamt};
                        entry.aluop = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                    end
                    default: entry = '0;
                endcase
                if (entry.aluop == ALU_ADD && funct != FN_ADD && funct != FN_ADDU) begin
                    entry         = '0;
                    entry.illegal = 1'b1;
                end
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
                entry.in1   = rs_val;
                entry.in2   = sext16(imm);
                entry.aluop = ALU_ADD;
            end
            OPC_SLTI: begin
                entry.in1   = rs_val;
                entry.in2   = sext16(imm);
                entry.aluop = ALU_SLT;
            end
            OPC_ANDI: begin
                entry.in1   = rs_val;
                entry.in2   = zext16(imm);
                entry.aluop = ALU_AND;
            end
            OPC_ORI: begin
                entry.in1   = rs_val;
                entry.in2   = zext16(imm);
                entry.aluop = ALU_OR;
            end
            OPC_BEQ: begin
                entry.in1   = rs_val;
                entry.in2   = rt_val;
                entry.aluop = ALU_SUB;
            end
            default: begin
                entry         = '0;
                entry.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes each offered instruction and holds it in a small in-order
// buffer until the ALU consumes it. Flush and reset drop everything buffered.
import alu_pkg::*;

module alu_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  aluop,
    output logic        illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    issue_entry_t   dec_entry;
    issue_entry_t   mem [DEPTH];
    issue_entry_t   head;
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;

    alu_decode u_decode (
        .instr  (instr),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .entry  (dec_entry)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: empty slots are never presented
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wptr] <= dec_entry;
    end

    assign head    = mem[rptr];
    assign alu_in1 = out_valid ? head.in1     : 32'h0;
    assign alu_in2 = out_valid ? head.in2     : 32'h0;
    assign aluop   = out_valid ? head.aluop   : 3'd0;
    assign illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus queues expected entries, a negedge monitor
// pops and compares them whenever the ALU side consumes the head.
import alu_pkg::*;

module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  aluop;
    logic        illegal;

    int passed = 0;
    int total  = 0;
    logic mon_en = 1'b0;
    issue_entry_t exp_q[$];

    alu_issue #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .aluop     (aluop),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic issue_entry_t mk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic ill);
        issue_entry_t e;
        e.in1     = a;
        e.in2     = b;
        e.aluop   = aluop_e'(op);
        e.illegal = ill;
        return e;
    endfunction

    function automatic issue_entry_t dut_entry();
        return mk(alu_in1, alu_in2, aluop, illegal);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_entry(input string name, input issue_entry_t act, input issue_entry_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got in1=%h in2=%h op=%0d ill=%b expected in1=%h in2=%h op=%0d ill=%b",
                      name, act.in1, act.in2, act.aluop, act.illegal,
                      exp.in1, exp.in2, exp.aluop, exp.illegal);
    endtask

    // monitor: compares the head at every consuming edge, and checks idle outputs are zero
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_issue: got in1=%h op=%0d with nothing expected", alu_in1, aluop);
                end else begin
                    check_entry("issue", dut_entry(), exp_q.pop_front());
                end
            end else if (!out_valid) begin
                check_entry("idle_zero", dut_entry(), mk(32'h0, 32'h0, 3'd0, 1'b0));
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] r, input logic [31:0] t,
                        input issue_entry_t e);
        int n;
        instr    = i;
        rs_val   = r;
        rt_val   = t;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                total++;
                $display("FAIL send_timeout: in_ready stayed 0 expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d entries outstanding expected 0", exp_q.size());
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = '0; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check32("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check_entry("reset_data", dut_entry(), mk(32'h0, 32'h0, 3'd0, 1'b0));
        @(posedge clk); #1;
        mon_en = 1'b1;

        // add latency into an empty buffer
        send(32'h00221820, 32'd5, 32'd7, mk(32'd5, 32'd7, 3'd0, 1'b0));
        @(negedge clk);
        check32("add_out_valid", {31'b0, out_valid}, 32'd1);
        check_entry("add_fields", dut_entry(), mk(32'd5, 32'd7, 3'd0, 1'b0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // decode vectors streamed back to back
        send(32'h00221822, 32'h10, 32'h3,        mk(32'h10, 32'h3, 3'd1, 1'b0));
        send(32'h00221823, 32'h20, 32'h4,        mk(32'h20, 32'h4, 3'd1, 1'b0));
        send(32'h00221824, 32'hF0F0, 32'hFF00,   mk(32'hF0F0, 32'hFF00, 3'd2, 1'b0));
        send(32'h00221825, 32'h1, 32'h2,         mk(32'h1, 32'h2, 3'd3, 1'b0));
        send(32'h00221827, 32'h3, 32'h4,         mk(32'h3, 32'h4, 3'd5, 1'b0));
        send(32'h0022182A, 32'h5, 32'h6,         mk(32'h5, 32'h6, 3'd4, 1'b0));
        send(32'h00221821, 32'h7, 32'h8,         mk(32'h7, 32'h8, 3'd0, 1'b0));
        send(32'h00031100, 32'hDEAD, 32'h11,     mk(32'h11, 32'd4, 3'd6, 1'b0));
        send(32'h000317C2, 32'hDEAD, 32'h80000000, mk(32'h80000000, 32'd31, 3'd7, 1'b0));
        send(32'h2041FFFF, 32'd10, 32'h99,       mk(32'd10, 32'hFFFFFFFF, 3'd0, 1'b0));
        send(32'h24418000, 32'd11, 32'h99,       mk(32'd11, 32'hFFFF8000, 3'd0, 1'b0));
        send(32'h3041FFFF, 32'd12, 32'h99,       mk(32'd12, 32'h0000FFFF, 3'd2, 1'b0));
        send(32'h34418000, 32'd13, 32'h99,       mk(32'd13, 32'h00008000, 3'd3, 1'b0));
        send(32'h28417FFF, 32'd14, 32'h99,       mk(32'd14, 32'h00007FFF, 3'd4, 1'b0));
        send(32'hFC000000, 32'h55, 32'h66,       mk(32'h0, 32'h0, 3'd0, 1'b1));
        send(32'h8C410004, 32'd15, 32'h99,       mk(32'd15, 32'd4, 3'd0, 1'b0));
        send(32'hAC41FFFC, 32'd16, 32'h99,       mk(32'd16, 32'hFFFFFFFC, 3'd0, 1'b0));
        send(32'h10220010, 32'd9, 32'd9,         mk(32'd9, 32'd9, 3'd1, 1'b0));
        send(32'h0022183F, 32'h1, 32'h2,         mk(32'h0, 32'h0, 3'd0, 1'b1));
        send(32'h00221803, 32'h1, 32'h2,         mk(32'h0, 32'h0, 3'd0, 1'b1));
        drain();

        // full buffer: third offer held while outputs keep the first entry
        out_ready = 1'b0;
        instr = 32'h00221820; rs_val = 32'hA1; rt_val = 32'hA2; in_valid = 1'b1;
        @(negedge clk);
        check32("full_ready0", {31'b0, in_ready}, 32'd1);
        exp_q.push_back(mk(32'hA1, 32'hA2, 3'd0, 1'b0));
        @(posedge clk); #1;
        instr = 32'h00221822; rs_val = 32'hB1; rt_val = 32'hB2;
        @(negedge clk);
        check32("full_ready1", {31'b0, in_ready}, 32'd1);
        exp_q.push_back(mk(32'hB1, 32'hB2, 3'd1, 1'b0));
        @(posedge clk); #1;
        instr = 32'h00221825; rs_val = 32'hC1; rt_val = 32'hC2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check32("full_ready_low", {31'b0, in_ready}, 32'd0);
            check_entry("full_hold_head", dut_entry(), mk(32'hA1, 32'hA2, 3'd0, 1'b0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(mk(32'hC1, 32'hC2, 3'd3, 1'b0));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // flush with a same-cycle offer
        out_ready = 1'b0;
        send(32'h00221820, 32'h11, 32'h12, mk(32'h11, 32'h12, 3'd0, 1'b0));
        send(32'h00221822, 32'h21, 32'h22, mk(32'h21, 32'h22, 3'd1, 1'b0));
        instr = 32'h00221824; rs_val = 32'h31; rt_val = 32'h32; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check32("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check32("flush_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00221825, 32'h41, 32'h42, mk(32'h41, 32'h42, 3'd3, 1'b0));
        drain();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h00221820, 32'h51, 32'h52, mk(32'h51, 32'h52, 3'd0, 1'b0));
        send(32'h00221822, 32'h61, 32'h62, mk(32'h61, 32'h62, 3'd1, 1'b0));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h00221827, 32'h71, 32'h72, mk(32'h71, 32'h72, 3'd5, 1'b0));
        drain();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, default 2, number of issue-buffer entries (power of two, at least 2).
REQ-002 Port: clk  input  1  sole clock, rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  decoded instruction and register values offered.
REQ-005 Port: in_ready  output  1  buffer can accept; high iff occupancy < DEPTH.
REQ-006 Port: instr  input  32  MIPS instruction word.
REQ-007 Port: rs_val  input  32  register-file value of rs.
REQ-008 Port: rt_val  input  32  register-file value of rt.
REQ-009 Port: flush  input  1  discard all buffered entries (branch taken / exception).
REQ-010 Port: out_valid  output  1  head entry valid for the ALU.
REQ-011 Port: out_ready  input  1  ALU stage consumes head.
REQ-012 Port: alu_in1  output  32  ALU operand 1.
REQ-013 Port: alu_in2  output  32  ALU operand 2.
REQ-014 Port: aluop  output  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 nor, 6 sll, 7 srl.
REQ-015 Port: illegal  output  1  head entry holds an unsupported instruction.

Function
REQ-016 Decode opcode 0x00 by funct: 0x20/0x21 -> add, 0x22/0x23 -> sub, 0x24 -> and, 0x25 -> or, 0x27 -> nor, 0x2A -> slt; in1=rs_val, in2=rt_val.
REQ-017 Shifts: funct 0x00 -> sll, 0x02 -> srl; in1=rt_val, in2={27'b0, shamt}.
REQ-018 I-type: 0x08, 0x09, 0x23, 0x2B -> add; 0x0A -> slt; in2=sign-extended imm16.
REQ-019 I-type: 0x0C -> and, 0x0D -> or; in2=zero-extended imm16; in1=rs_val for every I-type.
REQ-020 Opcode 0x04 (beq) -> sub, in1=rs_val, in2=rt_val; the ALU zero flag resolves the branch.
REQ-021 Any other opcode/funct: illegal=1, aluop=0, alu_in1=alu_in2=0; the entry is still buffered and issued in order.
REQ-022 Push occurs when in_valid&&in_ready at a rising edge; decode is performed before storage.
REQ-023 Pop occurs when out_valid&&out_ready at a rising edge.
REQ-024 Latency: an entry pushed into an empty buffer at edge N drives out_valid=1 and its fields after edge N.
REQ-025 Simultaneous push and pop when not full: occupancy unchanged, strict FIFO order kept.
REQ-026 Full: in_ready=0; in_valid is ignored and no entry is dropped or overwritten.
REQ-027 Empty: out_valid=0; alu_in1, alu_in2, aluop and illegal SHALL be 0.
REQ-028 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Read/write pointers wrap modulo DEPTH; occupancy counter has width clog2(DEPTH)+1.
REQ-030 flush=1 at an edge: occupancy becomes 0 and pointers reset; any same-cycle push or pop is discarded.
REQ-031 flush has priority over push and pop; in_ready=1 on the cycle after a flush.

Reset
REQ-032 rst=1 asynchronously clears pointers and occupancy; out_valid=0, in_ready=1 (once rst is deasserted), all data outputs 0.
REQ-033 Assertion of rst mid-stream discards all entries; the first push after deassertion is the next issued entry.

Structure
REQ-034 Shared package alu_pkg holds the aluop constants, opcode and funct constants, and the issue-entry struct (in1, in2, aluop, illegal).
REQ-035 One combinational sub-module alu_decode (instr, rs_val, rt_val -> entry); alu_issue instantiates it ahead of the buffer.

Verification
REQ-036 add $3,$1,$2 (0x00221820), rs_val=5, rt_val=7, empty buffer -> next cycle out_valid=1, aluop=0, in1=5, in2=7, illegal=0.
REQ-037 addi imm 0xFFFF -> in2=0xFFFFFFFF; andi imm 0xFFFF -> in2=0x0000FFFF, aluop=2.
REQ-038 sll $2,$3,4 (0x00031100), rt_val=0x11 -> aluop=6, in1=0x11, in2=4.
REQ-039 out_ready=0, three back-to-back pushes with DEPTH=2 -> in_ready=0 after the second; the third is held; outputs stay equal to the first entry; releasing out_ready issues all three in order.
REQ-040 Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered entry is never issued; rst asserted mid-stream -> immediate out_valid=0.
REQ-041 Opcode 0x3F -> issued in order with illegal=1, aluop=0, in1=in2=0.
